// File: rtl/arashi_thread_drain.sv
// -----------------------------------------------------------------------------
// arashi_thread_drain
//
// Read-side controller for a 3-entry thread cache. The cache has no
// empty/full flags and a 1-cycle read latency. This block keeps a mirror of
// the cache occupancy by snooping the producer's write strobe, and it issues
// cache reads only when the cache holds data. The registered cache output is
// turned into a valid/ready stream through a 2-entry skid buffer.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   cache_w_ena  : snoop of the producer's write strobe into the cache
//   cache_full   : mirror count == 3; producer must hold off writes
//   cache_r_ena  : read strobe to the cache (registered state + m_ready)
//   cache_data   : cache data_out, valid the cycle after cache_r_ena
//   m_valid      : output word valid
//   m_ready      : downstream accepts m_data when m_valid && m_ready
//   m_data       : output word, head of the skid buffer
//   wr_drop_err  : sticky, a write was seen while the cache was full
// -----------------------------------------------------------------------------
module arashi_thread_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cache_w_ena,
    output logic                  cache_full,
    output logic                  cache_r_ena,
    input  logic [DATA_WIDTH-1:0] cache_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  wr_drop_err
);

    localparam logic [2:0] OB_DEPTH_C = 3'(OBUF_DEPTH);

    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;
    logic                  rd_pend_q;
    logic [DATA_WIDTH-1:0] obuf_q [2];
    logic [DATA_WIDTH-1:0] obuf_d [2];
    logic [1:0]            ob_cnt_q;
    logic [1:0]            ob_cnt_d;
    logic                  err_q;
    logic                  err_d;

    logic                  w_acc_s;
    logic                  pop_s;
    logic                  r_ena_s;
    logic [2:0]            occ_s;
    logic [1:0]            ob_after_pop_s;

    // Outputs are decodes of registered state, except the read strobe which
    // must see this cycle's pop to sustain one word per cycle.
    assign m_valid     = (ob_cnt_q != 2'd0);
    assign m_data      = obuf_q[0];
    assign cache_full  = (cnt_q == 2'd3);
    assign wr_drop_err = err_q;
    assign cache_r_ena = r_ena_s;

    // Read issue decision and occupancy mirror update.
    always_comb begin
        w_acc_s = 1'b0;
        pop_s   = 1'b0;
        occ_s   = 3'd0;
        r_ena_s = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q;

        // The cache refuses a write at backlog 3 regardless of a same-cycle read.
        w_acc_s = cache_w_ena && (cnt_q != 2'd3);
        pop_s   = m_valid && m_ready;

        // Skid slots already claimed: buffered words plus the read in flight.
        // A slot is free when claimed < depth + pop.
        occ_s   = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q};
        r_ena_s = (cnt_q != 2'd0) && (occ_s < (OB_DEPTH_C + {2'b00, pop_s}));

        case ({w_acc_s, r_ena_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | (cache_w_ena && (cnt_q == 2'd3));
    end

    // Skid buffer: shift on pop first, then land the returning read at the tail.
    always_comb begin
        obuf_d         = obuf_q;
        ob_after_pop_s = ob_cnt_q;
        ob_cnt_d       = ob_cnt_q;

        if (pop_s) begin
            obuf_d[0]      = obuf_q[1];
            ob_after_pop_s = ob_cnt_q - 2'd1;
        end else begin
            ob_after_pop_s = ob_cnt_q;
        end

        if (rd_pend_q) begin
            case (ob_after_pop_s)
                2'd0:    obuf_d[0] = cache_data;
                2'd1:    obuf_d[1] = cache_data;
                default: obuf_d[1] = cache_data;
            endcase
            ob_cnt_d = ob_after_pop_s + 2'd1;
        end else begin
            ob_cnt_d = ob_after_pop_s;
        end
    end

    // State registers with synchronous reset; reset discards any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 2'd0;
            rd_pend_q <= 1'b0;
            ob_cnt_q  <= 2'd0;
            obuf_q[0] <= '0;
            obuf_q[1] <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rd_pend_q <= r_ena_s;
            ob_cnt_q  <= ob_cnt_d;
            obuf_q[0] <= obuf_d[0];
            obuf_q[1] <= obuf_d[1];
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_arashi_thread_drain.sv
// -----------------------------------------------------------------------------
// tb_arashi_thread_drain
//
// Self-checking bench: a behavioural 3-entry cache sits between the producer
// stimulus and the DUT; every word the cache accepts is pushed to a scoreboard
// and popped/compared when the DUT hands it downstream. A cycle table covers
// the single-word and fill cases; hand-written sequences cover streaming,
// backpressure, overflow and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_arashi_thread_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_w_ena;
    logic        cache_full;
    logic        cache_r_ena;
    logic [31:0] cache_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        wr_drop_err;

    logic [31:0] wdata;

    arashi_thread_drain #(.DATA_WIDTH(32), .OBUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cache_w_ena (cache_w_ena),
        .cache_full  (cache_full),
        .cache_r_ena (cache_r_ena),
        .cache_data  (cache_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .wr_drop_err (wr_drop_err)
    );

    always #5 clk = ~clk;

    // Behavioural cache: 3 entries, refuses writes at backlog 3, registered read.
    logic [31:0] mdl_mem [3];
    logic [1:0]  mdl_cnt;
    logic [1:0]  mdl_wp;
    logic [1:0]  mdl_rp;
    logic [31:0] mdl_dout;
    logic        mdl_wacc;

    assign mdl_wacc   = cache_w_ena && (mdl_cnt != 2'd3);
    assign cache_data = mdl_dout;

    always @(posedge clk) begin
        if (rst) begin
            mdl_cnt  <= 2'd0;
            mdl_wp   <= 2'd0;
            mdl_rp   <= 2'd0;
            mdl_dout <= 32'd0;
        end else begin
            if (mdl_wacc) begin
                mdl_mem[mdl_wp] <= wdata;
                mdl_wp <= (mdl_wp == 2'd2) ? 2'd0 : mdl_wp + 2'd1;
            end
            if (cache_r_ena) begin
                mdl_dout <= mdl_mem[mdl_rp];
                mdl_rp <= (mdl_rp == 2'd2) ? 2'd0 : mdl_rp + 2'd1;
            end
            if (mdl_wacc && !cache_r_ena)
                mdl_cnt <= mdl_cnt + 2'd1;
            else if (!mdl_wacc && cache_r_ena)
                mdl_cnt <= mdl_cnt - 2'd1;
        end
    end

    typedef struct packed {
        logic        w;
        logic [31:0] d;
        logic        rdy;
        logic        e_full;
        logic        e_rena;
        logic        e_valid;
        logic [31:0] e_data;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] sb [$];
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    int          cyc      = 0;
    int          pop_cnt  = 0;
    int          first_pop = 0;
    int          last_pop  = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = 32'd0;
    logic        obey_full  = 1'b0;
    logic        full_seen  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One cycle: drive after the rising edge, sample on the falling edge.
    task automatic step(input logic w, input logic [31:0] d, input logic rdy, output logic wrote);
        @(posedge clk);
        #1;
        cyc++;
        if (obey_full && cache_full) w = 1'b0;
        cache_w_ena = w;
        wdata       = d;
        m_ready     = rdy;
        wrote       = w;
        if (w && mdl_cnt != 2'd3) sb.push_back(d);
        @(negedge clk);
        if (cache_full) full_seen = 1'b1;
        if (stall_prev) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", m_data, stall_data);
        end
        stall_prev = m_valid && !m_ready;
        stall_data = m_data;
        if (m_valid && m_ready) begin
            if (sb.size() == 0) chk("unexpected_word", m_data, 32'hFFFF_FFFF);
            else chk("sb_data", m_data, sb.pop_front());
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
        end
    endtask

    initial begin
        logic wr;
        int   written;
        int   guard;

        // Cycle table: test 1 (rows 0-4) then test 2 fill/drain (rows 5-13).
        tbl[0]  = '{1'b1, 32'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'hA5};
        tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 32'h1,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h2,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 32'h3,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h1};
        tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h1};
        tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1};
        tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h2};
        tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h3};
        tbl[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        rst = 1'b1; cache_w_ena = 1'b0; m_ready = 1'b0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, m_valid},     32'd0);
        chk("rst_data",  m_data,               32'd0);
        chk("rst_full",  {31'd0, cache_full},  32'd0);
        chk("rst_rena",  {31'd0, cache_r_ena}, 32'd0);
        chk("rst_err",   {31'd0, wr_drop_err}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].rdy, wr);
            chk($sformatf("tbl%0d_full", i),  {31'd0, cache_full},  {31'd0, tbl[i].e_full});
            chk($sformatf("tbl%0d_rena", i),  {31'd0, cache_r_ena}, {31'd0, tbl[i].e_rena});
            chk($sformatf("tbl%0d_valid", i), {31'd0, m_valid},     {31'd0, tbl[i].e_valid});
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), m_data, tbl[i].e_data);
        end

        // Streaming: 20 back-to-back writes, m_ready high.
        pop_cnt = 0; full_seen = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b1, 32'h100 + i, 1'b1, wr);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, wr);
        chk("stream_count", pop_cnt, 20);
        chk("stream_no_bubble", last_pop - first_pop, 19);
        chk("stream_full", {31'd0, full_seen}, 32'd0);
        chk("stream_sb_empty", sb.size(), 0);

        // Backpressure: m_ready alternates, producer respects cache_full.
        pop_cnt = 0; written = 0; guard = 0; obey_full = 1'b1;
        while (written < 20 && guard < 200) begin
            step(1'b1, 32'h200 + written, guard[0], wr);
            if (wr) written++;
            guard++;
        end
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            step(1'b0, 32'h0, guard[0], wr);
            guard++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, wr);
        obey_full = 1'b0;
        chk("bp_written", written, 20);
        chk("bp_count", pop_cnt, 20);
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_err", {31'd0, wr_drop_err}, 32'd0);

        // Overflow: fill skid + cache, then write while full.
        pop_cnt = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 32'h10 + i, 1'b0, wr);
        step(1'b1, 32'hDEAD, 1'b0, wr);
        chk("ovf_full", {31'd0, cache_full}, 32'd1);
        chk("ovf_rena_blocked", {31'd0, cache_r_ena}, 32'd0);
        step(1'b0, 32'h0, 1'b0, wr);
        chk("ovf_err", {31'd0, wr_drop_err}, 32'd1);
        chk("ovf_full_hold", {31'd0, cache_full}, 32'd1);
        step(1'b1, 32'hBEEF, 1'b1, wr);
        chk("ovf_rd_with_wr", {31'd0, cache_r_ena}, 32'd1);
        step(1'b0, 32'h0, 1'b1, wr);
        chk("ovf_full_drop", {31'd0, cache_full}, 32'd0);
        guard = 0;
        while (sb.size() != 0 && guard < 30) begin
            step(1'b0, 32'h0, 1'b1, wr);
            guard++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, wr);
        chk("ovf_count", pop_cnt, 5);
        chk("ovf_sb_empty", sb.size(), 0);
        chk("ovf_err_sticky", {31'd0, wr_drop_err}, 32'd1);

        // Reset mid-stream with a read in flight.
        step(1'b1, 32'h50, 1'b1, wr);
        step(1'b0, 32'h0, 1'b1, wr);
        chk("rmid_rena", {31'd0, cache_r_ena}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1; cache_w_ena = 1'b0; m_ready = 1'b0;
        sb.delete(); stall_prev = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rmid_valid", {31'd0, m_valid},     32'd0);
        chk("rmid_full",  {31'd0, cache_full},  32'd0);
        chk("rmid_err",   {31'd0, wr_drop_err}, 32'd0);
        chk("rmid_rena0", {31'd0, cache_r_ena}, 32'd0);
        pop_cnt = 0;
        step(1'b1, 32'h7, 1'b1, wr);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, wr);
        chk("rmid_count", pop_cnt, 1);
        chk("rmid_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
